// File: rtl/adc_arbiter_pkg.sv
// Shared types and frame constants for the ADC arbiter and its serial engine.
package adc_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        FINISH,
        GAP
    } adc_state_e;

    localparam int ADC_CMD_BITS   = 5;
    localparam int ADC_NULL_BITS  = 2;
    localparam int ADC_DATA_BITS  = 12;
    localparam int ADC_FRAME_BITS = 19;

    // First data bit position in the frame (bits are numbered from 1).
    localparam int ADC_DATA_FIRST = ADC_CMD_BITS + ADC_NULL_BITS + 1;

    localparam logic [1:0] ADC_START_SGL = 2'b11;

    // Command bit idx (1..5) of the frame: start, single-ended, D2, D1, D0.
    function automatic logic adc_cmd_bit(input logic [2:0] chan, input logic [2:0] idx);
        logic [ADC_CMD_BITS-1:0] cmd;
        logic [2:0]              pos;
        cmd = {ADC_START_SGL, chan};
        pos = 3'(ADC_CMD_BITS) - idx;
        return cmd[pos];
    endfunction

endpackage

// File: rtl/adc_arbiter_serial.sv
// Serial engine for the shared-DIO 12-bit ADC: SETUP/SHIFT/FINISH timing,
// AdcClk divider, command shift-out, DIO direction and data capture.
module adc_serial_engine
    import adc_arbiter_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  chan,
    input  logic        adc_in,
    output logic        adc_cs,
    output logic        adc_clk,
    output logic        adc_out,
    output logic        adc_dir,
    output logic        done,
    output logic [11:0] result,
    output logic        setup_last,
    output logic        shift_last
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

    adc_state_e                 state_q, state_d;
    logic [DW-1:0]              div_q, div_d;
    logic [4:0]                 bit_q, bit_d;
    logic [2:0]                 chan_q, chan_d;
    logic [ADC_DATA_BITS-1:0]   shift_q, shift_d;
    logic [ADC_DATA_BITS-1:0]   result_q, result_d;
    logic                       cs_q, cs_d;
    logic                       sclk_q, sclk_d;
    logic                       out_q, out_d;
    logic                       dir_q, dir_d;
    logic                       done_q, done_d;

    // Frame sequencing: each AdcClk phase lasts CLK_DIV cycles, edges are
    // taken when the divider reaches zero.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        chan_d   = chan_q;
        shift_d  = shift_q;
        result_d = result_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        out_d    = out_q;
        dir_d    = dir_q;
        done_d   = 1'b0;

        setup_last = (state_q == SETUP) && (div_q == '0);
        shift_last = (state_q == SHIFT) && (div_q == '0) && sclk_q &&
                     (bit_q == 5'(ADC_FRAME_BITS));

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    chan_d  = chan;
                    div_d   = DIV_LOAD;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b0;
                    dir_d   = 1'b1;
                    out_d   = adc_cmd_bit(chan, 3'd1);
                    shift_d = '0;
                end
            end
            SETUP: begin
                if (div_q == '0) begin
                    state_d = SHIFT;
                    bit_d   = 5'd1;
                    div_d   = DIV_LOAD;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DW'(1);
                end else begin
                    div_d = DIV_LOAD;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (bit_q >= 5'(ADC_DATA_FIRST)) begin
                            shift_d = {shift_q[ADC_DATA_BITS-2:0], adc_in};
                        end
                    end else if (bit_q == 5'(ADC_FRAME_BITS)) begin
                        state_d  = FINISH;
                        sclk_d   = 1'b0;
                        cs_d     = 1'b1;
                        out_d    = 1'b0;
                        dir_d    = 1'b0;
                        done_d   = 1'b1;
                        result_d = shift_q;
                    end else begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 5'd1;
                        if (bit_q < 5'(ADC_CMD_BITS)) begin
                            out_d = adc_cmd_bit(chan_q, 3'(bit_q + 5'd1));
                        end else if (bit_q == 5'(ADC_CMD_BITS)) begin
                            // Release DIO so the ADC can drive it from the sample bit on.
                            dir_d = 1'b0;
                            out_d = 1'b0;
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Engine registers; reset aborts any frame and parks the ADC pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            chan_q   <= '0;
            shift_q  <= '0;
            result_q <= '0;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            out_q    <= 1'b0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            chan_q   <= chan_d;
            shift_q  <= shift_d;
            result_q <= result_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            out_q    <= out_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
        end
    end

    assign adc_cs  = cs_q;
    assign adc_clk = sclk_q;
    assign adc_out = out_q;
    assign adc_dir = dir_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule

// File: rtl/adc_arbiter.sv
// Arbiter for the shared motor-board ADC. Requester 0 (back-EMF) has fixed
// priority; requesters 1..NREQ-1 share round-robin. Optional starvation guard
// for the round-robin requesters is enabled with ADC_STARVE_GUARD_EN.
//
// state  | meaning
// IDLE   | arbitrate pending requests
// SETUP  | AdcCs low, AdcClk held low before the first bit
// SHIFT  | 19 AdcClk periods: command, sample, null, 12 data bits
// FINISH | Done pulse, Result updated, AdcCs high
// GAP    | AdcCs held high until CS_HIGH cycles since FINISH
module adc_arbiter
    import adc_arbiter_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int CLK_DIV    = 4,
    parameter int CS_HIGH    = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NREQ-1:0]   Req,
    input  logic [3*NREQ-1:0] ReqChan,
    output logic [NREQ-1:0]   Grant,
    output logic              Done,
    output logic [11:0]       Result,
    output logic              Busy,
    output logic              AdcCs,
    output logic              AdcClk,
    output logic              AdcOut,
    output logic              AdcDir,
    input  logic              AdcIn
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("adc_arbiter: NREQ must be 2..8");
    end
    if (CLK_DIV < 1 || CS_HIGH < 1 || STARVE_MAX < 1) begin : g_bad_timing
        $error("adc_arbiter: CLK_DIV, CS_HIGH and STARVE_MAX must be >= 1");
    end

    localparam int GW = (CS_HIGH > 2) ? $clog2(CS_HIGH) : 1;
    // FINISH counts as the first AdcCs-high cycle of the gap.
    localparam logic [GW-1:0] GAP_LOAD = GW'((CS_HIGH > 2) ? CS_HIGH - 2 : 0);

    adc_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   gap_q, gap_d;

    logic            start;
    logic            take0;
    logic [2:0]      win_idx;
    logic [2:0]      rr_idx;
    logic [2:0]      hi_idx, lo_idx;
    logic            hi_found;
    logic [2:0]      chan_sel;
    logic            eng_setup_last;
    logic            eng_shift_last;

`ifdef ADC_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0]   starve_q, starve_d;
    logic            others;
`endif

    // Arbitration, grant and top-level sequencing.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        gap_d    = gap_q;
        start    = 1'b0;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        chan_sel = '0;

        // Lowest pending index at/above the pointer, else lowest pending overall.
        for (int i = NREQ - 1; i >= 1; i--) begin
            if (Req[i]) begin
                lo_idx = 3'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end
            end
        end
        rr_idx = hi_found ? hi_idx : lo_idx;

`ifdef ADC_STARVE_GUARD_EN
        others = |Req[NREQ-1:1];
        take0  = Req[0] && !(others && (starve_q == SW'(STARVE_MAX)));
`else
        take0  = Req[0];
`endif
        win_idx = take0 ? 3'd0 : rr_idx;

        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == 3'(i)) begin
                chan_sel = ReqChan[3*i +: 3];
            end
        end

        case (state_q)
            IDLE: begin
                if (|Req) begin
                    start   = 1'b1;
                    state_d = SETUP;
                    grant_d = NREQ'(1) << win_idx;
                    if (!take0) begin
                        rr_ptr_d = (win_idx == 3'(NREQ - 1)) ? 3'd1 : win_idx + 3'd1;
                    end
                end
            end
            SETUP: begin
                if (eng_setup_last) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (eng_shift_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                grant_d = '0;
                gap_d   = GAP_LOAD;
                state_d = GAP;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= 3'd1;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            gap_q    <= gap_d;
        end
    end

`ifdef ADC_STARVE_GUARD_EN
    // Count back-to-back requester-0 wins that pass over a pending requester.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && |Req) begin
            if (!take0) begin
                starve_d = '0;
            end else if (others) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    adc_serial_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk        (Clk),
        .rst        (Reset),
        .start      (start),
        .chan       (chan_sel),
        .adc_in     (AdcIn),
        .adc_cs     (AdcCs),
        .adc_clk    (AdcClk),
        .adc_out    (AdcOut),
        .adc_dir    (AdcDir),
        .done       (Done),
        .result     (Result),
        .setup_last (eng_setup_last),
        .shift_last (eng_shift_last)
    );

    assign Grant = grant_q;
    assign Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_adc_arbiter.sv
// Directed bench for adc_arbiter with a cycle-level model of the serial ADC.
module tb_adc_arbiter;

    localparam int NREQ       = 3;
    localparam int CLK_DIV    = 2;
    localparam int CS_HIGH    = 8;
    localparam int STARVE_MAX = 4;

    logic              Clk     = 1'b0;
    logic              Reset   = 1'b1;
    logic [NREQ-1:0]   Req     = '0;
    logic [3*NREQ-1:0] ReqChan = '0;
    logic [NREQ-1:0]   Grant;
    logic              Done;
    logic [11:0]       Result;
    logic              Busy;
    logic              AdcCs;
    logic              AdcClk;
    logic              AdcOut;
    logic              AdcDir;
    logic              AdcIn   = 1'b0;

    adc_arbiter #(
        .NREQ       (NREQ),
        .CLK_DIV    (CLK_DIV),
        .CS_HIGH    (CS_HIGH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Req     (Req),
        .ReqChan (ReqChan),
        .Grant   (Grant),
        .Done    (Done),
        .Result  (Result),
        .Busy    (Busy),
        .AdcCs   (AdcCs),
        .AdcClk  (AdcClk),
        .AdcOut  (AdcOut),
        .AdcDir  (AdcDir),
        .AdcIn   (AdcIn)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // ADC model, observed on the falling Clk edge.
    logic [11:0] model_data = '0;
    logic [11:0] tx_sr      = '0;
    logic        prev_cs    = 1'b1;
    logic        prev_clk   = 1'b0;
    int          fall_cnt   = 0;
    int          rise_cnt   = 0;
    logic [4:0]  cmd_obs    = '0;
    logic        dir_hi_bad = 1'b0;
    logic        dir_lo_bad = 1'b0;

    always @(negedge Clk) begin
        prev_cs  <= AdcCs;
        prev_clk <= AdcClk;
        if (prev_cs && !AdcCs) begin
            fall_cnt   <= 0;
            rise_cnt   <= 0;
            cmd_obs    <= '0;
            dir_hi_bad <= 1'b0;
            dir_lo_bad <= 1'b0;
            tx_sr      <= model_data;
        end else if (!AdcCs) begin
            if (prev_clk && !AdcClk) begin
                fall_cnt <= fall_cnt + 1;
                if (fall_cnt + 1 >= 7 && fall_cnt + 1 <= 18) begin
                    AdcIn <= tx_sr[11];
                    tx_sr <= {tx_sr[10:0], 1'b0};
                end
            end
            if (!prev_clk && AdcClk) begin
                rise_cnt <= rise_cnt + 1;
                if (rise_cnt < 5) begin
                    cmd_obs <= {cmd_obs[3:0], AdcOut};
                    if (!AdcDir) dir_hi_bad <= 1'b1;
                end else if (AdcDir) begin
                    dir_lo_bad <= 1'b1;
                end
            end
        end
    end

    // Bus monitors.
    int   done_cnt    = 0;
    int   onehot_bad  = 0;
    logic track2      = 1'b0;
    logic grant2_seen = 1'b0;
    logic gap_track   = 1'b0;
    int   hi_run      = 0;
    int   min_gap     = 1000;

    always @(negedge Clk) begin
        if (Done) done_cnt <= done_cnt + 1;
        if ($countones(Grant) > 1) onehot_bad <= onehot_bad + 1;
        if (track2 && Grant[2]) grant2_seen <= 1'b1;
        if (!gap_track) begin
            hi_run <= 0;
        end else if (AdcCs) begin
            hi_run <= hi_run + 1;
        end else begin
            if (hi_run > 0 && hi_run < min_gap) min_gap <= hi_run;
            hi_run <= 0;
        end
    end

    int vectors = 0;
    int errs    = 0;

`ifdef ADC_STARVE_GUARD_EN
    int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
`else
    int exp_order[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    int exp_alt[4] = '{1, 2, 1, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int gc, output logic [2:0] g);
        logic ok;
        ok = 1'b0;
        gc = 0;
        g  = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (Grant != '0) begin
                ok = 1'b1;
                gc = cyc;
                g  = Grant;
                break;
            end
        end
        chk("grant_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk);
            if (Done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        Req   = '0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    function automatic int oh2idx(input logic [2:0] g);
        case (g)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0;
        int         gc;
        int         d0;
        logic [2:0] g;

        // Reset state
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_grant",  32'(Grant),  32'd0);
        chk("rst_done",   32'(Done),   32'd0);
        chk("rst_result", 32'(Result), 32'd0);
        chk("rst_busy",   32'(Busy),   32'd0);
        chk("rst_cs",     32'(AdcCs),  32'd1);
        chk("rst_sclk",   32'(AdcClk), 32'd0);
        chk("rst_out",    32'(AdcOut), 32'd0);
        chk("rst_dir",    32'(AdcDir), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Single conversion, requester 1, channel 5
        model_data = 12'hA5C;
        ReqChan    = {3'd0, 3'd5, 3'd0};
        @(posedge Clk);
        #1;
        Req = 3'b010;
        t0  = cyc;
        wait_grant(gc, g);
        chk("t1_grant",     32'(g), 32'b010);
        chk("t1_grant_lat", 32'(gc - t0), 32'd1);
        chk("t1_busy",      32'(Busy), 32'd1);
        wait_done();
        chk("t1_latency",   32'(cyc - gc), 32'd78);
        chk("t1_result",    32'(Result), 32'hA5C);
        chk("t1_done_grant",32'(Grant), 32'b010);
        Req = 3'b000;
        @(negedge Clk);
        chk("t1_done_pulse",32'(Done), 32'd0);
        chk("t1_grant_drop",32'(Grant), 32'd0);
        chk("t1_cmd_bits",  32'(cmd_obs), 32'b11101);
        chk("t1_dir_cmd",   32'(dir_hi_bad), 32'd0);
        chk("t1_dir_read",  32'(dir_lo_bad), 32'd0);

        // All requesters held: priority order
        do_reset();
        model_data = 12'h5A5;
        ReqChan    = {3'd2, 3'd1, 3'd0};
        Req        = 3'b111;
        for (int k = 0; k < 10; k++) begin
            wait_done();
            chk($sformatf("t2_order_%0d", k), 32'(oh2idx(Grant)), 32'(exp_order[k]));
        end
        chk("t2_result", 32'(Result), 32'h5A5);

        // Requesters 1 and 2 held: alternation and CS-high gap
        Req       = 3'b110;
        gap_track = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done();
            chk($sformatf("t3_alt_%0d", k), 32'(oh2idx(Grant)), 32'(exp_alt[k]));
        end
        Req       = 3'b000;
        gap_track = 1'b0;
        chk("t3_cs_gap_ge8", 32'((min_gap >= CS_HIGH) ? 1 : 0), 32'd1);

        // Reset in the middle of SHIFT
        do_reset();
        model_data = 12'h3C5;
        ReqChan    = {3'd0, 3'd0, 3'd3};
        Req        = 3'b001;
        wait_grant(gc, g);
        chk("t4_grant", 32'(g), 32'b001);
        repeat (CLK_DIV + 30) @(posedge Clk);
        #1;
        chk("t4_cs_pre", 32'(AdcCs), 32'd0);
        d0    = done_cnt;
        Reset = 1'b1;
        Req   = 3'b000;
        #1;
        chk("t4_cs",    32'(AdcCs),  32'd1);
        chk("t4_sclk",  32'(AdcClk), 32'd0);
        chk("t4_grant0",32'(Grant),  32'd0);
        chk("t4_busy",  32'(Busy),   32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (100) @(posedge Clk);
        #1;
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
        Req = 3'b001;
        wait_done();
        chk("t4_clean_result", 32'(Result), 32'h3C5);
        chk("t4_clean_grant",  32'(Grant),  32'b001);
        chk("t4_clean_cmd",    32'(cmd_obs), 32'b11011);
        Req = 3'b000;

        // Requester 2 pulsed during a requester-1 conversion
        repeat (20) @(posedge Clk);
        #1;
        model_data = 12'h123;
        ReqChan    = {3'd6, 3'd2, 3'd0};
        Req        = 3'b010;
        wait_grant(gc, g);
        chk("t5_grant", 32'(g), 32'b010);
        @(posedge Clk);
        #1;
        track2 = 1'b1;
        d0     = done_cnt;
        Req    = 3'b110;
        @(posedge Clk);
        #1;
        Req = 3'b010;
        wait_done();
        chk("t5_done_grant", 32'(Grant),  32'b010);
        chk("t5_result",     32'(Result), 32'h123);
        chk("t5_cmd",        32'(cmd_obs), 32'b11010);
        Req = 3'b000;
        repeat (40) @(posedge Clk);
        #1;
        chk("t5_one_done",   32'(done_cnt - d0), 32'd1);
        chk("t5_no_grant2",  32'(grant2_seen), 32'd0);
        track2 = 1'b0;

        // Full-scale then zero, result holds between pulses
        model_data = 12'hFFF;
        Req        = 3'b010;
        wait_done();
        chk("t6_fff", 32'(Result), 32'hFFF);
        Req = 3'b000;
        repeat (30) @(posedge Clk);
        @(negedge Clk);
        chk("t6_hold", 32'(Result), 32'hFFF);
        model_data = 12'h000;
        Req        = 3'b010;
        wait_done();
        chk("t6_zero", 32'(Result), 32'h000);
        Req = 3'b000;

        @(negedge Clk);
        chk("onehot_grant", 32'(onehot_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/adc_arbiter.md
Name: adc_arbiter

Overview:
- Owns the single shared serial ADC (8-channel, 12-bit, shared DIO pin) on the motor board.
- Arbitrates conversion requests from NREQ requesters and sequences the serial transaction.
- Requester 0 is the back-EMF measurement engine and has fixed priority. Requesters 1..NREQ-1 (host analog reads, sensor scan) share the remaining slots round-robin.
- Returns one 12-bit result per grant.

Parameters:
NREQ, 3, number of requesters (2..8)
CLK_DIV, 4, AdcClk half-period in Clk cycles (>=1)
CS_HIGH, 8, minimum AdcCs-high Clk cycles between conversions (>=1)
STARVE_MAX, 4, max consecutive requester-0 grants while others pend (ADC_STARVE_GUARD_EN only)

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
Req  in  NREQ  per-requester conversion request, level
ReqChan  in  3*NREQ  channel select, requester i at bits [3i+2:3i]
Grant  out  NREQ  one-hot, high for granted requester during its transaction
Done  out  1  one-cycle pulse, Result valid
Result  out  12  last conversion result, held until next Done
Busy  out  1  high in any state other than IDLE
AdcCs  out  1  ADC chip select, active low
AdcClk  out  1  ADC serial clock
AdcOut  out  1  serial command data to ADC
AdcDir  out  1  1 = drive shared DIO with AdcOut, 0 = tristate/read
AdcIn  in  1  serial data from ADC

Behaviour:
- Reset values, asynchronous: Grant=0, Done=0, Result=0, Busy=0, AdcCs=1, AdcClk=0, AdcOut=0, AdcDir=0. State = IDLE, round-robin pointer = 1, starve count = 0.
- Reset during a conversion aborts it immediately. No Done is issued.
- States: IDLE -> SETUP -> SHIFT -> FINISH -> GAP -> IDLE.
- IDLE, arbitration:
  - If any Req bit is high, the winner is registered.
  - Req[0] wins if high.
  - Otherwise the first high Req[i], searching from the RR pointer upward and wrapping over 1..NREQ-1, wins.
  - ReqChan of the winner is latched.
  - Next cycle: Grant[winner]=1, AdcCs=0, Busy=1; state goes to SETUP.
  - RR pointer advances to winner+1 (wrapping to 1) only when a non-zero requester wins.
- SETUP: AdcCs low, AdcClk low for CLK_DIV cycles. AdcDir=1, AdcOut = first command bit.
- SHIFT: 19 AdcClk periods, each CLK_DIV low then CLK_DIV high.
  - Bits 1-5 are command bits: start=1, single-ended=1, D2, D1, D0. AdcDir=1. AdcOut changes only on Clk cycles where AdcClk falls, or on SETUP entry for bit 1.
  - Bit 6 is the sample period. AdcDir drops to 0 at the falling edge ending bit 5.
  - Bit 7 is the null bit and is ignored.
  - Bits 8-19 are data, MSB first. AdcIn is sampled on the Clk cycle where AdcClk rises and shifted into a 12-bit register.
- FINISH: one cycle after the final AdcClk high phase ends.
  - AdcClk=0, AdcCs=1, Done=1, Result updated.
  - Grant drops the following cycle.
- GAP: AdcCs high for CS_HIGH cycles total, counted from FINISH. No arbitration occurs until GAP exits.
- Latency: Grant rise to Done = CLK_DIV + 38*CLK_DIV cycles (CLK_DIV=2 gives 78).
- Req handshake:
  - A requester holds Req until it sees Done with its Grant high.
  - Req dropped before Grant is a cancellation and is ignored.
  - Req dropped during a transaction does not abort it.
  - Req still high after Done is a new request.
- Simultaneous requests: one grant per transaction. Never more than one Grant bit is set.
- ReqChan changes after latching have no effect.

Optional Feature:
- Macro: ADC_STARVE_GUARD_EN.
- Defined:
  - A counter increments on each requester-0 grant made while any other Req was high, and clears on any non-zero grant.
  - When the counter equals STARVE_MAX and another requester pends, requester 0 loses one arbitration to the round-robin winner.
- Undefined: pure fixed priority for requester 0. The counter and STARVE_MAX are unused.

Decomposition:
- Package adc_arbiter_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, FINISH, GAP)
  - constants ADC_CMD_BITS=5, ADC_NULL_BITS=2, ADC_DATA_BITS=12, ADC_FRAME_BITS=19
  - ADC_START_SGL=2'b11
- Sub-module adc_serial_engine owns SETUP/SHIFT/FINISH timing, the clock divider, the shift register, and the AdcDir control. It has a start/channel input and a done/result output.
- adc_arbiter keeps arbitration, Grant, the round-robin pointer, the starve guard, and GAP.

Test Plan:
- Setup for all scenarios: NREQ=3, CLK_DIV=2, CS_HIGH=8, bench ADC model.
- Req[1]=1, ReqChan ch5, model returns 0xA5C -> Grant=3'b010 next cycle. AdcOut command bits 1,1,1,0,1 with AdcDir=1. AdcDir=0 from bit 6. Done 78 cycles after Grant, Result=0xA5C, single pulse.
- Req=3'b111 held continuously -> grant order 0,0,0... (guard off). With ADC_STARVE_GUARD_EN: 0,0,0,0,1,0,0,0,0,2.
- Req[0]=0, Req[1]=Req[2]=1 held -> alternating grants 1,2,1,2. Consecutive AdcCs-high gap >=8 cycles.
- Reset asserted 30 cycles into SHIFT -> same cycle: AdcCs=1, AdcClk=0, Grant=0, Busy=0. No Done. Next Req gives a full clean conversion.
- Req[2] pulsed for one cycle while a requester-1 conversion runs -> no grant to 2. Result and Done belong to 1 only.
- Model returns 0xFFF then 0x000 -> Result 0xFFF then 0x000. Result holds between Done pulses.
